serial_rx: RTL and testbench

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_pkg.sv | 24 ++
 rtl/bit_sync.sv | 31 +++
 rtl/serial_rx.sv | 140 ++++++++++++++
 tb/tb_serial_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: state encoding and small helpers used by serial_rx and serial_tx.
package serial_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
   localparam logic [2:0] ST_RESYNC = 3'd4;

   typedef enum logic [2:0] {
      StIdle   = ST_IDLE,
      StStart  = ST_START,
      StData   = ST_DATA,
      StStop   = ST_STOP,
      StResync = ST_RESYNC
   } serial_state_e;

   localparam int unsigned BIT_CTR_W = 14;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer, reset to 0. With SERIAL_RX_MAJORITY_EN the first stage is also
// exported as a one-cycle look-ahead of the synchronized value.
module bit_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
`ifdef SERIAL_RX_MAJORITY_EN
   output logic q_early,
`endif
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;
`ifdef SERIAL_RX_MAJORITY_EN
   assign q_early = meta_q;
`endif

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: high start bit, PKT_LENGTH data bits LSB first, low stop bit.
// Define SERIAL_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit midpoint.
module serial_rx
   import serial_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = 13540,
   parameter int unsigned PKT_LENGTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic [PKT_LENGTH-1:0] data,
   output logic                  new_data,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int unsigned CW    = $clog2(CLK_PER_BIT);
   localparam int unsigned IDX_W = (PKT_LENGTH > 1) ? $clog2(PKT_LENGTH) : 1;

   localparam logic [CW-1:0]        HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]        BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [BIT_CTR_W-1:0] DATA_LAST = BIT_CTR_W'(PKT_LENGTH - 1);

   serial_state_e         state_q, state_d;
   logic [CW-1:0]         cyc_q, cyc_d;
   logic [BIT_CTR_W-1:0]  bit_q, bit_d;
   logic [PKT_LENGTH-1:0] shift_q, shift_d;
   logic [PKT_LENGTH-1:0] data_q, data_d;
   logic                  new_data_q, new_data_d;
   logic                  frame_err_q, frame_err_d;
   logic                  rx_s;
   logic                  sample;

`ifdef SERIAL_RX_MAJORITY_EN
   logic rx_early;
   logic rx_prev_q;

   bit_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .d       (rx),
      .q_early (rx_early),
      .q       (rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) rx_prev_q <= 1'b0;
      else     rx_prev_q <= rx_s;
   end

   // The first sync stage already holds the value rx_s takes next cycle, so the vote over
   // target-1/target/target+1 resolves at target and frame timing is unchanged.
   assign sample = maj3(rx_prev_q, rx_s, rx_early);
`else
   bit_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign sample = rx_s;
`endif

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q + 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      data_d      = data_q;
      new_data_d  = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            cyc_d = '0;
            bit_d = '0;
            if (rx_s) state_d = StStart;
         end
         StStart: begin
            if (cyc_q == HALF_LAST) begin
               cyc_d   = '0;
               state_d = sample ? StData : StIdle;
            end
         end
         StData: begin
            if (cyc_q == BIT_LAST) begin
               cyc_d                    = '0;
               shift_d[bit_q[IDX_W-1:0]] = sample;
               bit_d                    = bit_q + 1'b1;
               if (bit_q == DATA_LAST) state_d = StStop;
            end
         end
         StStop: begin
            if (cyc_q == BIT_LAST) begin
               cyc_d = '0;
               if (sample) begin
                  state_d     = StResync;
                  frame_err_d = 1'b1;
               end else begin
                  state_d    = StIdle;
                  data_d     = shift_q;
                  new_data_d = 1'b1;
               end
            end
         end
         StResync: begin
            cyc_d = '0;
            if (!rx_s) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cyc_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         new_data_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         new_data_q  <= new_data_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign data      = data_q;
   assign new_data  = new_data_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx (CLK_PER_BIT=16, PKT_LENGTH=8) with a task-based line driver.
// Expected glitch-test result follows SERIAL_RX_MAJORITY_EN.
module tb_serial_rx;

   localparam int CPB = 16;
   localparam int P   = 8;
   localparam int LAT = 2 + CPB / 2 + (P + 1) * CPB + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         rx;
   logic [P-1:0] data;
   logic         new_data;
   logic         busy;
   logic         frame_err;

   serial_rx #(
      .CLK_PER_BIT (CPB),
      .PKT_LENGTH  (P)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .new_data  (new_data),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc = 0;
   int nd_cnt = 0, fe_cnt = 0, overlap = 0, wide = 0, nd_lat = 0;
   logic nd_prev = 1'b0, fe_prev = 1'b0;
   logic [P-1:0] rxq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: counts pulses and records every delivered payload.
   always @(negedge clk) begin
      if (new_data) begin
         nd_cnt = nd_cnt + 1;
         rxq.push_back(data);
         nd_lat = cyc - start_cyc;
      end
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (new_data && frame_err) overlap = overlap + 1;
      if ((new_data && nd_prev) || (frame_err && fe_prev)) wide = wide + 1;
      nd_prev = new_data;
      fe_prev = frame_err;
   end

   task automatic idle(input int n);
      rx = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame from a negedge; rst_bit >= 0 pulses rst mid data bit and abandons the frame.
   task automatic send_frame(input logic [P-1:0] b, input logic stop, input bit glitch,
                             input int rst_bit);
      logic v;
      start_cyc = cyc;
      for (int slot = 0; slot <= P + 1; slot++) begin
         if (slot == 0)          v = 1'b1;
         else if (slot == P + 1) v = stop;
         else                    v = b[slot-1];
         for (int c = 0; c < CPB; c++) begin
            if (rst_bit >= 0 && slot == rst_bit + 1 && c == CPB / 2) begin
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
               rx  = 1'b0;
               return;
            end
            rx = (glitch && slot >= 1 && slot <= P && c == CPB / 2) ? 1'b0 : v;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx  = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (data !== '0)       begin bad++; $display("FAIL reset_data got=%h want=00", data); end
      total++; if (new_data !== 1'b0) begin bad++; $display("FAIL reset_new_data got=%b want=0", new_data); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
      rst = 1'b0;
      idle(5);
   endtask

   task automatic test_single;
      int n0 = nd_cnt, f0 = fe_cnt;
      send_frame(8'hA5, 1'b0, 1'b0, -1);
      idle(4);
      total++; if (nd_cnt - n0 != 1) begin bad++; $display("FAIL single_pulses got=%0d want=1", nd_cnt - n0); end
      total++; if (data !== 8'hA5)    begin bad++; $display("FAIL single_data got=%h want=a5", data); end
      total++; if (fe_cnt != f0)      begin bad++; $display("FAIL single_frame_err got=%0d want=0", fe_cnt - f0); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
      total++; if (nd_lat != LAT)     begin bad++; $display("FAIL single_latency got=%0d want=%0d", nd_lat, LAT); end
   endtask

   task automatic test_back_to_back;
      int n0 = nd_cnt;
      int q0 = rxq.size();
      send_frame(8'h00, 1'b0, 1'b0, -1);
      send_frame(8'hFF, 1'b0, 1'b0, -1);
      idle(4);
      total++; if (nd_cnt - n0 != 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", nd_cnt - n0); end
      total++;
      if (rxq.size() < q0 + 2) begin
         bad++; $display("FAIL b2b_data got=%0d frames want=2", rxq.size() - q0);
      end else if (rxq[q0] !== 8'h00 || rxq[q0+1] !== 8'hFF) begin
         bad++; $display("FAIL b2b_data got=%h,%h want=00,ff", rxq[q0], rxq[q0+1]);
      end
   endtask

   task automatic test_start_glitch;
      int n0 = nd_cnt, f0 = fe_cnt;
      logic [P-1:0] d0 = data;
      rx = 1'b1;
      repeat (4) @(negedge clk);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_mid got=%b want=1", busy); end
      idle(30);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", busy); end
      total++;
      if (nd_cnt != n0 || fe_cnt != f0) begin
         bad++; $display("FAIL glitch_pulses got nd=%0d fe=%0d want=0", nd_cnt - n0, fe_cnt - f0);
      end
      total++; if (data !== d0) begin bad++; $display("FAIL glitch_data got=%h want=%h", data, d0); end
   endtask

   task automatic test_frame_err;
      int n0 = nd_cnt, f0 = fe_cnt;
      logic [P-1:0] d0 = data;
      send_frame(8'h3C, 1'b1, 1'b0, -1);
      repeat (40) @(negedge clk);
      total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", fe_cnt - f0); end
      total++; if (nd_cnt != n0)     begin bad++; $display("FAIL ferr_new_data got=%0d want=0", nd_cnt - n0); end
      total++; if (data !== d0)      begin bad++; $display("FAIL ferr_data got=%h want=%h", data, d0); end
      total++; if (busy !== 1'b1)    begin bad++; $display("FAIL ferr_resync_busy got=%b want=1", busy); end
      idle(5);
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL ferr_release got=%b want=0", busy); end
   endtask

   task automatic test_reset_mid;
      int n0 = nd_cnt, f0 = fe_cnt;
      send_frame(8'h5A, 1'b0, 1'b0, 4);
      idle(40);
      total++;
      if (nd_cnt != n0 || fe_cnt != f0) begin
         bad++; $display("FAIL rstmid_pulses got nd=%0d fe=%0d want=0", nd_cnt - n0, fe_cnt - f0);
      end
      total++; if (data !== '0)   begin bad++; $display("FAIL rstmid_data got=%h want=00", data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      send_frame(8'h5A, 1'b0, 1'b0, -1);
      idle(4);
      total++; if (nd_cnt - n0 != 1) begin bad++; $display("FAIL rstmid_resend_pulses got=%0d want=1", nd_cnt - n0); end
      total++; if (data !== 8'h5A)   begin bad++; $display("FAIL rstmid_resend_data got=%h want=5a", data); end
   endtask

   task automatic test_mid_glitch;
      logic [P-1:0] exp;
`ifdef SERIAL_RX_MAJORITY_EN
      exp = 8'hFF;
`else
      exp = 8'h00;
`endif
      send_frame(8'hFF, 1'b0, 1'b1, -1);
      idle(4);
      total++; if (data !== exp) begin bad++; $display("FAIL midglitch_data got=%h want=%h", data, exp); end
   endtask

   task automatic test_random;
      logic [P-1:0] exp[$];
      logic [P-1:0] b;
      int n0 = nd_cnt;
      int q0 = rxq.size();
      for (int i = 0; i < 8; i++) begin
         b = P'($urandom);
         exp.push_back(b);
         send_frame(b, 1'b0, 1'b0, -1);
         idle($urandom_range(0, 12));
      end
      idle(4);
      total++; if (nd_cnt - n0 != 8) begin bad++; $display("FAIL random_pulses got=%0d want=8", nd_cnt - n0); end
      for (int i = 0; i < 8 && q0 + i < rxq.size(); i++) begin
         total++;
         if (rxq[q0+i] !== exp[i]) begin
            bad++; $display("FAIL random_data[%0d] got=%h want=%h", i, rxq[q0+i], exp[i]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_start_glitch;
      test_frame_err;
      test_reset_mid;
      test_mid_glitch;
      test_random;
      total++; if (overlap != 0) begin bad++; $display("FAIL pulse_overlap got=%0d want=0", overlap); end
      total++; if (wide != 0)    begin bad++; $display("FAIL pulse_width got=%0d want=0", wide); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
